// File: rtl/ram_refresh_ctl_pkg.sv
// Shared types and default timing for the RAM refresh responder.
// Contents: FSM state enum, default TCSR/TRAS/TRP, counter load helper.
package ref_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOCK,
        CAS,
        RAS,
        PRE
    } state_t;

    localparam int TCSR_DEF = 1;
    localparam int TRAS_DEF = 4;
    localparam int TRP_DEF  = 3;

    // Phase counters count down to zero, so a phase of N cycles loads N-1.
    function automatic logic [2:0] cnt_load(input int cycles);
        return 3'(cycles - 1);
    endfunction

endpackage

// File: rtl/ram_refresh_ctl_if.sv
// Bus bundle between the refresh responder and the RAM controller side.
// slave: the responder (takes requests/bus state, drives strobes/status).
// master: the surrounding logic (drives requests/bus state).
interface ram_refresh_ctl_if;

    logic RefReq;
    logic RefUrgent;
    logic BACT;
    logic RAMIdle;
    logic RAMLock;
    logic nRASref;
    logic nCASref;
    logic RefDone;
    logic RefMiss;

    modport slave (
        input  RefReq, RefUrgent, BACT, RAMIdle,
        output RAMLock, nRASref, nCASref, RefDone, RefMiss
    );

    modport master (
        output RefReq, RefUrgent, BACT, RAMIdle,
        input  RAMLock, nRASref, nCASref, RefDone, RefMiss
    );

endinterface

// File: rtl/ram_refresh_ctl_sync2.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
// Ports: clk, rst (sync, active-high), d (async in), q (synchronized out).
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/ram_refresh_ctl.sv
// CAS-before-RAS refresh responder: one refresh per RefReq rising edge.
// Ports: FCLK, RES (sync active-high), bus (requests in, strobes/lock out).
module ram_refresh_ctl
    import ref_pkg::*;
#(
    parameter int TCSR = TCSR_DEF,
    parameter int TRAS = TRAS_DEF,
    parameter int TRP  = TRP_DEF
) (
    input  logic             FCLK,
    input  logic             RES,
    ram_refresh_ctl_if.slave bus
);

    state_t     state, state_n;
    logic [2:0] cnt, cnt_n;
    logic       req_s, urg_s, prev;
    logic       pending;
    logic       req_rise, enter_cas, done;

    sync2 u_sync_req (
        .clk (FCLK),
        .rst (RES),
        .d   (bus.RefReq),
        .q   (req_s)
    );

    sync2 u_sync_urg (
        .clk (FCLK),
        .rst (RES),
        .d   (bus.RefUrgent),
        .q   (urg_s)
    );

    assign req_rise  = req_s & ~prev;
    assign enter_cas = (state == LOCK) & bus.RAMIdle;
    assign done      = (state == PRE) & (cnt == 3'd0);

    always_comb begin
        state_n = state;
        cnt_n   = (cnt == 3'd0) ? cnt : cnt - 3'd1;
        unique case (state)
            IDLE: begin
                if (pending && ((!bus.BACT && bus.RAMIdle) || urg_s))
                    state_n = LOCK;
            end
            LOCK: begin
                if (bus.RAMIdle) begin
                    state_n = CAS;
                    cnt_n   = cnt_load(TCSR);
                end
            end
            CAS: begin
                if (cnt == 3'd0) begin
                    state_n = RAS;
                    cnt_n   = cnt_load(TRAS);
                end
            end
            RAS: begin
                if (cnt == 3'd0) begin
                    state_n = PRE;
                    cnt_n   = cnt_load(TRP);
                end
            end
            PRE: begin
                if (cnt == 3'd0)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge FCLK) begin
        if (RES) begin
            state       <= IDLE;
            cnt         <= 3'd0;
            prev        <= 1'b0;
            pending     <= 1'b0;
            bus.RefMiss <= 1'b0;
            bus.RAMLock <= 1'b0;
            bus.nRASref <= 1'b1;
            bus.nCASref <= 1'b1;
            bus.RefDone <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            prev  <= req_s;
            // A request arriving as CAS starts is queued, not lost.
            if (enter_cas)
                pending <= req_rise;
            else if (req_rise)
                pending <= 1'b1;
            if (req_rise && pending && !enter_cas)
                bus.RefMiss <= 1'b1;
            // Strobes are decoded from the next state so they leave a flop.
            bus.RAMLock <= (state_n != IDLE);
            bus.nCASref <= !((state_n == CAS) || (state_n == RAS));
            bus.nRASref <= (state_n != RAS);
            bus.RefDone <= done;
        end
    end

endmodule

// File: tb/tb_ram_refresh_ctl.sv
// Directed self-checking bench for ram_refresh_ctl.
// Drives requests/bus state through the interface, checks strobes and status.
module tb_ram_refresh_ctl;

    logic FCLK = 1'b0;
    logic RES  = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cnt_a, cnt_b;

    ram_refresh_ctl_if bus ();

    ram_refresh_ctl dut (
        .FCLK (FCLK),
        .RES  (RES),
        .bus  (bus)
    );

    always #5 FCLK = ~FCLK;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge FCLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_req();
        bus.RefReq = 1'b1;
        tick();
        bus.RefReq = 1'b0;
    endtask

    initial begin
        bus.RefReq    = 1'b0;
        bus.RefUrgent = 1'b0;
        bus.BACT      = 1'b0;
        bus.RAMIdle   = 1'b1;
        RES           = 1'b1;
        tick(2);
        RES = 1'b0;
        chk("rst_nras", 16'(bus.nRASref), 16'd1);
        chk("rst_ncas", 16'(bus.nCASref), 16'd1);
        chk("rst_lock", 16'(bus.RAMLock), 16'd0);
        chk("rst_done", 16'(bus.RefDone), 16'd0);
        chk("rst_miss", 16'(bus.RefMiss), 16'd0);
        tick(3);

        // 1: idle bus, single request
        pulse_req();
        tick(2);
        chk("t1_lock_e3", 16'(bus.RAMLock), 16'd0);
        tick();
        chk("t1_lock_e4", 16'(bus.RAMLock), 16'd1);
        chk("t1_ncas_e4", 16'(bus.nCASref), 16'd1);
        tick();
        chk("t1_ncas_e5", 16'(bus.nCASref), 16'd0);
        chk("t1_nras_e5", 16'(bus.nRASref), 16'd1);
        tick();
        chk("t1_nras_e6", 16'(bus.nRASref), 16'd0);
        chk("t1_ncas_e6", 16'(bus.nCASref), 16'd0);
        tick(3);
        chk("t1_nras_e9", 16'(bus.nRASref), 16'd0);
        tick();
        chk("t1_nras_e10", 16'(bus.nRASref), 16'd1);
        chk("t1_ncas_e10", 16'(bus.nCASref), 16'd1);
        chk("t1_lock_e10", 16'(bus.RAMLock), 16'd1);
        tick(2);
        chk("t1_lock_e12", 16'(bus.RAMLock), 16'd1);
        chk("t1_done_e12", 16'(bus.RefDone), 16'd0);
        tick();
        chk("t1_lock_e13", 16'(bus.RAMLock), 16'd0);
        chk("t1_done_e13", 16'(bus.RefDone), 16'd1);
        tick();
        chk("t1_done_e14", 16'(bus.RefDone), 16'd0);
        tick(3);

        // 2: busy bus defers a plain request
        bus.BACT = 1'b1;
        pulse_req();
        cnt_a = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.RAMLock || !bus.nCASref || !bus.nRASref)
                cnt_a++;
        end
        chk("t2_held_off", 16'(cnt_a), 16'd0);
        bus.BACT = 1'b0;
        tick();
        chk("t2_lock", 16'(bus.RAMLock), 16'd1);
        tick();
        chk("t2_ncas", 16'(bus.nCASref), 16'd0);
        tick(8);
        chk("t2_done", 16'(bus.RefDone), 16'd1);
        tick(3);

        // 3: urgency bypasses BACT but still waits for RAMIdle
        bus.BACT    = 1'b1;
        bus.RAMIdle = 1'b0;
        pulse_req();
        tick(5);
        chk("t3_no_lock", 16'(bus.RAMLock), 16'd0);
        bus.RefUrgent = 1'b1;
        tick(3);
        chk("t3_lock", 16'(bus.RAMLock), 16'd1);
        cnt_a = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!bus.RAMLock || !bus.nCASref)
                cnt_a++;
        end
        chk("t3_hold", 16'(cnt_a), 16'd0);
        bus.RAMIdle = 1'b1;
        tick();
        chk("t3_ncas", 16'(bus.nCASref), 16'd0);
        bus.RefUrgent = 1'b0;
        tick(8);
        chk("t3_done", 16'(bus.RefDone), 16'd1);
        bus.BACT = 1'b0;
        tick(3);

        // 4: two requests while blocked, one is lost
        bus.BACT = 1'b1;
        pulse_req();
        tick(300);
        pulse_req();
        tick(5);
        chk("t4_miss", 16'(bus.RefMiss), 16'd1);
        chk("t4_nolock", 16'(bus.RAMLock), 16'd0);
        bus.BACT = 1'b0;
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.RefDone) cnt_a++;
            if (!bus.nRASref) cnt_b++;
        end
        chk("t4_dones", 16'(cnt_a), 16'd1);
        chk("t4_ras_cyc", 16'(cnt_b), 16'd4);
        RES = 1'b1;
        tick();
        RES = 1'b0;
        chk("t4_miss_clr", 16'(bus.RefMiss), 16'd0);
        tick(3);

        // 5: reset in the middle of RAS
        pulse_req();
        tick(5);
        chk("t5_in_ras", 16'(bus.nRASref), 16'd0);
        RES = 1'b1;
        tick();
        RES = 1'b0;
        chk("t5_nras", 16'(bus.nRASref), 16'd1);
        chk("t5_ncas", 16'(bus.nCASref), 16'd1);
        chk("t5_lock", 16'(bus.RAMLock), 16'd0);
        cnt_a = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.RefDone || bus.RAMLock) cnt_a++;
        end
        chk("t5_no_done", 16'(cnt_a), 16'd0);

        // 6: second request lands on the CAS entry edge
        bus.RefReq = 1'b1;
        tick();
        bus.RefReq = 1'b0;
        tick();
        bus.RefReq = 1'b1;
        tick();
        bus.RefReq = 1'b0;
        tick(2);
        chk("t6_ncas_e5", 16'(bus.nCASref), 16'd0);
        tick(8);
        chk("t6_done1", 16'(bus.RefDone), 16'd1);
        chk("t6_lock_e13", 16'(bus.RAMLock), 16'd0);
        tick();
        chk("t6_relock", 16'(bus.RAMLock), 16'd1);
        cnt_a = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.RefDone) cnt_a++;
        end
        chk("t6_done2", 16'(cnt_a), 16'd1);
        chk("t6_miss", 16'(bus.RefMiss), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
